// File: rtl/serial_tx_engine.sv
`default_nettype none
// ============================================================================
// Module   : serial_tx_engine
// Purpose  : Parallel-in / serial-out transmitter. It accepts DATA_W-bit words,
//            each with its own mode (half or full width, LSB or MSB first),
//            and streams them out one bit per clk. A one-word pending slot
//            lets back-to-back frames be sent without a gap.
// Revision : 1.0 - initial release
//
// Optional feature:
//   SERIAL_TX_PARITY_EN - when defined, a parity bit is appended after the
//                         data bits of every frame. The parity bit is
//                         XOR(data bits) ^ PARITY_ODD, and so_last moves to it.
//
// Parameters:
//   DATA_W      word width; even, >= 4
//   PARITY_ODD  parity sense (0 even, 1 odd); used only with the parity feature
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous active-high reset
//   load      in   word offer; accepted when load && pi_ready at a clk edge
//   pi_ready  out  engine can accept a word this cycle (0 during reset)
//   pi_data   in   parallel word, sampled on acceptance
//   pi_msb    in   1: MSB first, 0: LSB first; sampled on acceptance
//   pi_low    in   1: all DATA_W bits, 0: low DATA_W/2 bits; sampled on acceptance
//   so_data   out  serial bit; 0 whenever so_valid is 0 (registered)
//   so_valid  out  so_data carries a frame bit (registered)
//   so_last   out  current bit is the final bit of its frame (registered)
// ============================================================================
module serial_tx_engine #(
    parameter int DATA_W     = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    output logic              pi_ready,
    input  logic [DATA_W-1:0] pi_data,
    input  logic              pi_msb,
    input  logic              pi_low,
    output logic              so_data,
    output logic              so_valid,
    output logic              so_last
);

    localparam int               c_IDX_W    = $clog2(DATA_W);
    localparam logic [c_IDX_W-1:0] c_IDX_FULL = c_IDX_W'(DATA_W - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_HALF = c_IDX_W'(DATA_W / 2 - 1);

    // Elaboration-time sanity checks on the parameters.
    if ((DATA_W < 4) || ((DATA_W % 2) != 0)) begin : g_bad_data_w
        $error("serial_tx_engine: DATA_W must be even and >= 4");
    end
    if ((PARITY_ODD != 0) && (PARITY_ODD != 1)) begin : g_bad_parity_odd
        $error("serial_tx_engine: PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t              state_q;
    logic [DATA_W-1:0]   act_data_q;
    logic                act_msb_q;
    logic                act_low_q;
    logic [c_IDX_W-1:0]  idx_q;        // index of the bit currently on so_data

    logic                pend_full_q;
    logic [DATA_W-1:0]   pend_data_q;
    logic                pend_msb_q;
    logic                pend_low_q;

    logic                so_data_q;
    logic                so_valid_q;
    logic                so_last_q;

    // ------------------------------------------------------------------
    // Next-state helpers
    // ------------------------------------------------------------------
    logic                accept_d;     // handshake completes at this edge
    logic                start_d;      // a new frame begins at this edge
    logic                start_pend_d; // ... and it comes from the pending slot
    logic                store_pend_d; // accepted word parks in the pending slot
    logic [DATA_W-1:0]   start_data_d;
    logic                start_msb_d;
    logic                start_low_d;
    logic [c_IDX_W-1:0]  start_idx_d;
    logic                start_bit_d;
    logic [c_IDX_W-1:0]  act_end_idx_d; // index of the last data bit of the active frame
    logic [c_IDX_W-1:0]  idx_step_d;    // index of the next data bit

    assign pi_ready = ~pend_full_q & ~reset;
    assign accept_d = load & pi_ready;

    always_comb begin
        start_d      = 1'b0;
        start_pend_d = 1'b0;
        store_pend_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                start_d = accept_d;
            end
            ST_SHIFT: begin
                if (so_last_q) begin
                    // Frame ends this edge: a queued word has priority; if
                    // the slot is empty a word offered now starts directly.
                    if (pend_full_q) begin
                        start_d      = 1'b1;
                        start_pend_d = 1'b1;
                    end else begin
                        start_d = accept_d;
                    end
                end else begin
                    store_pend_d = accept_d;
                end
            end
            default: begin
                start_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        start_data_d = start_pend_d ? pend_data_q : pi_data;
        start_msb_d  = start_pend_d ? pend_msb_q  : pi_msb;
        start_low_d  = start_pend_d ? pend_low_q  : pi_low;
        if (start_msb_d) begin
            start_idx_d = start_low_d ? c_IDX_FULL : c_IDX_HALF;
        end else begin
            start_idx_d = '0;
        end
        start_bit_d = start_data_d[start_idx_d];
    end

    always_comb begin
        if (act_msb_q) begin
            act_end_idx_d = '0;
            idx_step_d    = idx_q - 1'b1;
        end else begin
            act_end_idx_d = act_low_q ? c_IDX_FULL : c_IDX_HALF;
            idx_step_d    = idx_q + 1'b1;
        end
    end

`ifdef SERIAL_TX_PARITY_EN
    localparam logic c_PARITY_SENSE = PARITY_ODD[0];

    // Parity covers the same set of bits regardless of transmit order, so
    // it is taken straight from the latched word under the width mask.
    logic [DATA_W-1:0] par_mask_d;
    logic              par_bit_d;
    logic              at_data_end_d;

    assign par_mask_d    = act_low_q ? {DATA_W{1'b1}}
                                     : {{(DATA_W/2){1'b0}}, {(DATA_W/2){1'b1}}};
    assign par_bit_d     = (^(act_data_q & par_mask_d)) ^ c_PARITY_SENSE;
    assign at_data_end_d = (idx_q == act_end_idx_d);
`endif

    // ------------------------------------------------------------------
    // Control FSM with registered serial outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            act_data_q  <= '0;
            act_msb_q   <= 1'b0;
            act_low_q   <= 1'b0;
            idx_q       <= '0;
            pend_full_q <= 1'b0;
            pend_data_q <= '0;
            pend_msb_q  <= 1'b0;
            pend_low_q  <= 1'b0;
            so_data_q   <= 1'b0;
            so_valid_q  <= 1'b0;
            so_last_q   <= 1'b0;
        end else begin
            // Pending slot: fill and drain never coincide, because a drain
            // only happens when the slot is full and pi_ready is then 0.
            if (store_pend_d) begin
                pend_full_q <= 1'b1;
                pend_data_q <= pi_data;
                pend_msb_q  <= pi_msb;
                pend_low_q  <= pi_low;
            end else if (start_pend_d) begin
                pend_full_q <= 1'b0;
            end

            if (start_d) begin
                state_q    <= ST_SHIFT;
                act_data_q <= start_data_d;
                act_msb_q  <= start_msb_d;
                act_low_q  <= start_low_d;
                idx_q      <= start_idx_d;
                so_data_q  <= start_bit_d;
                so_valid_q <= 1'b1;
                so_last_q  <= 1'b0;   // a frame is always at least two bits
            end else begin
                case (state_q)
                    ST_SHIFT: begin
                        if (so_last_q) begin
                            state_q    <= ST_IDLE;
                            so_data_q  <= 1'b0;
                            so_valid_q <= 1'b0;
                            so_last_q  <= 1'b0;
                        end else begin
`ifdef SERIAL_TX_PARITY_EN
                            if (at_data_end_d) begin
                                // Data exhausted: emit the parity bit as the
                                // frame's final bit; the index stays put.
                                so_data_q <= par_bit_d;
                                so_last_q <= 1'b1;
                            end else begin
                                idx_q     <= idx_step_d;
                                so_data_q <= act_data_q[idx_step_d];
                                so_last_q <= 1'b0;
                            end
`else
                            idx_q     <= idx_step_d;
                            so_data_q <= act_data_q[idx_step_d];
                            so_last_q <= (idx_step_d == act_end_idx_d);
`endif
                            so_valid_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q    <= ST_IDLE;
                        so_data_q  <= 1'b0;
                        so_valid_q <= 1'b0;
                        so_last_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign so_data  = so_data_q;
    assign so_valid = so_valid_q;
    assign so_last  = so_last_q;

endmodule : serial_tx_engine
`default_nettype wire
